adder_arbiter: RTL and testbench

Two-port scheduler for the single 16-bit ripple-carry adder in the accumulator datapath. Two requesters share one adder instance and ask for either ACCUM (add operand to their private accumulator) or LOAD (overwrite their private accumulator). Round-robin arbitration decides which requester is served. The block keeps one 17-bit accumulator per port, with bit 16 holding the carry, and returns the result with a one-cycle done pulse.

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/adder_arbiter_rca.sv | 23 ++
 rtl/adder_arbiter_rr_arb2.sv | 21 ++
 rtl/adder_arbiter.sv | 138 +++++++++++++
 tb/tb_adder_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-port adder scheduler.
package adder_arb_pkg;

   localparam int NUM_PORTS = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      ACCUM = 1'b0,
      LOAD  = 1'b1
   } op_t;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/adder_arbiter_rca.sv
// Shared ripple-carry adder; carry chains bit by bit from cin to cout.
module ripple_carry_adder_16_bit #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH:0] carry_s;

   assign carry_s[0] = cin_i;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
      assign carry_s[i + 1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = carry_s[WIDTH];

endmodule

// File: rtl/adder_arbiter_rr_arb2.sv
// Two-way round-robin grant decode; purely combinational, registered by the caller.
module rr_arb2
   import adder_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 last_i,
   output logic [NUM_PORTS-1:0] gnt_o
);

   // On a tie the port that was not served last wins.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = port_onehot(~last_i);
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; each owns a WIDTH+1 bit accumulator (MSB = last carry).
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] op_i,
   input  logic [WIDTH-1:0]     operand0_i,
   input  logic [WIDTH-1:0]     operand1_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [NUM_PORTS-1:0] done_o,
   output logic [WIDTH:0]       result0_o,
   output logic [WIDTH:0]       result1_o,
   output logic                 busy_o
);

   state_t                 state_q, state_d;
   logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
   logic [NUM_PORTS-1:0]   done_q, done_d;
   op_t                    op_q, op_d;
   logic [WIDTH-1:0]       operand_q, operand_d;
   logic [WIDTH:0]         acc0_q, acc0_d;
   logic [WIDTH:0]         acc1_q, acc1_d;
   logic                   last_q, last_d;

   logic [NUM_PORTS-1:0]   arb_gnt_s;
   logic                   sel_s;
   logic [WIDTH-1:0]       add_b_s;
   logic [WIDTH-1:0]       sum_s;
   logic                   cout_s;
   logic [WIDTH:0]         new_acc_s;

   rr_arb2 u_arb (
      .req_i  (req_i),
      .last_i (last_q),
      .gnt_o  (arb_gnt_s)
   );

   ripple_carry_adder_16_bit #(.WIDTH(WIDTH)) u_adder (
      .a_i    (operand_q),
      .b_i    (add_b_s),
      .cin_i  (1'b0),
      .sum_o  (sum_s),
      .cout_o (cout_s)
   );

   assign sel_s = gnt_q[1];

   // Operand muxes: pick the owning port's accumulator and the op's write-back value.
   always_comb begin
      if (sel_s) begin
         add_b_s = acc1_q[WIDTH-1:0];
      end else begin
         add_b_s = acc0_q[WIDTH-1:0];
      end
      if (op_q == LOAD) begin
         new_acc_s = {1'b0, operand_q};
      end else begin
         new_acc_s = {cout_s, sum_s};
      end
   end

   // Next-state logic; req is only looked at in IDLE so late requests simply wait.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      done_d    = 2'b00;
      op_d      = op_q;
      operand_d = operand_q;
      acc0_d    = acc0_q;
      acc1_d    = acc1_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               gnt_d     = arb_gnt_s;
               op_d      = op_t'(arb_gnt_s[1] ? op_i[1] : op_i[0]);
               operand_d = arb_gnt_s[1] ? operand1_i : operand0_i;
               state_d   = EXEC;
            end else begin
               gnt_d   = 2'b00;
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (sel_s) begin
               acc1_d = new_acc_s;
            end else begin
               acc0_d = new_acc_s;
            end
            last_d  = sel_s;
            done_d  = gnt_q;
            state_d = RESP;
         end
         RESP: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         op_q      <= ACCUM;
         operand_q <= '0;
         acc0_q    <= '0;
         acc1_q    <= '0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         acc0_q    <= acc0_d;
         acc1_q    <= acc1_d;
         last_q    <= last_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign done_o    = done_q;
   assign result0_o = acc0_q;
   assign result1_o = acc1_q;
   assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed plus randomized checks of adder_arbiter against an arithmetic reference model.
module tb_adder_arbiter;

   localparam logic OP_ACCUM = 1'b0;
   localparam logic OP_LOAD  = 1'b1;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  op;
   logic [15:0] operand0;
   logic [15:0] operand1;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [16:0] result0;
   logic [16:0] result1;
   logic        busy;

   int tests = 0;
   int fails = 0;

   logic [16:0] m_acc [2];
   int          m_last;

   adder_arbiter #(.WIDTH(16)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .req_i      (req),
      .op_i       (op),
      .operand0_i (operand0),
      .operand1_i (operand1),
      .gnt_o      (gnt),
      .done_o     (done),
      .result0_o  (result0),
      .result1_o  (result1),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   // Reference: LOAD replaces, ACCUM adds to the low 16 bits with a fresh carry.
   task automatic model_apply(input int p, input logic o, input logic [15:0] v);
      if (o == OP_LOAD) begin
         m_acc[p] = {1'b0, v};
      end else begin
         m_acc[p] = {1'b0, m_acc[p][15:0]} + {1'b0, v};
      end
      m_last = p;
   endtask

   task automatic model_reset();
      m_acc[0] = 17'h0;
      m_acc[1] = 17'h0;
      m_last   = 1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 2'b00;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_results(input string tag);
      check({tag, "_r0"}, result0, m_acc[0]);
      check({tag, "_r1"}, result1, m_acc[1]);
   endtask

   // One uncontended operation on port p, checking every cycle of its timeline.
   task automatic single(input int p, input logic o, input logic [15:0] v);
      req    = 2'b00;
      req[p] = 1'b1;
      op[p]  = o;
      if (p == 0) operand0 = v;
      else        operand1 = v;
      tick();
      check("exec_gnt", 17'(gnt), 17'(onehot(p)));
      check("exec_busy", 17'(busy), 17'h1);
      check("exec_done", 17'(done), 17'h0);
      req      = 2'b00;
      operand0 = 16'($urandom);
      operand1 = 16'($urandom);
      model_apply(p, o, v);
      tick();
      check("resp_done", 17'(done), 17'(onehot(p)));
      check("resp_gnt", 17'(gnt), 17'(onehot(p)));
      check_results("resp");
      tick();
      check("idle_gnt", 17'(gnt), 17'h0);
      check("idle_busy", 17'(busy), 17'h0);
      check("idle_done", 17'(done), 17'h0);
   endtask

   // Both ports request continuously for n operations; winners must alternate.
   task automatic contend(input int n, input logic o0, input logic o1,
                          input logic [15:0] v0, input logic [15:0] v1);
      int cnt;
      int w;
      op       = {o1, o0};
      operand0 = v0;
      operand1 = v1;
      req      = 2'b11;
      for (int k = 0; k < n; k++) begin
         cnt = 0;
         tick();
         while (done == 2'b00 && cnt < 8) begin
            tick();
            cnt++;
         end
         w = (m_last == 0) ? 1 : 0;
         check("rr_done", 17'(done), 17'(onehot(w)));
         model_apply(w, (w == 1) ? o1 : o0, (w == 1) ? v1 : v0);
         check_results("rr");
         if (k == n - 1) req = 2'b00;
      end
      tick();
      check("rr_end_busy", 17'(busy), 17'h0);
      tick();
      check("rr_end_gnt", 17'(gnt), 17'h0);
   endtask

   initial begin
      reset    = 1'b1;
      req      = 2'b00;
      op       = 2'b00;
      operand0 = 16'h0;
      operand1 = 16'h0;
      model_reset();

      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_gnt", 17'(gnt), 17'h0);
         check("rst_done", 17'(done), 17'h0);
         check("rst_busy", 17'(busy), 17'h0);
         check("rst_r0", result0, 17'h0);
         check("rst_r1", result1, 17'h0);
      end

      single(0, OP_LOAD, 16'h1234);
      check("p0_load", result0, 17'h01234);
      single(0, OP_ACCUM, 16'h0001);
      check("p0_accum", result0, 17'h01235);
      check("p1_untouched", result1, 17'h0);

      single(1, OP_LOAD, 16'hFFFF);
      single(1, OP_ACCUM, 16'h0001);
      check("wrap_carry", result1, 17'h10000);
      single(1, OP_ACCUM, 16'h0002);
      check("wrap_next", result1, 17'h00002);

      do_reset();
      contend(4, OP_ACCUM, OP_ACCUM, 16'h0001, 16'h0001);
      check("rr4_r0", result0, 17'h00002);
      check("rr4_r1", result1, 17'h00002);

      // Reset during EXEC discards the operation.
      single(0, OP_LOAD, 16'h00AA);
      req      = 2'b01;
      op[0]    = OP_ACCUM;
      operand0 = 16'h0005;
      tick();
      check("mid_exec_gnt", 17'(gnt), 17'h1);
      reset = 1'b1;
      req   = 2'b00;
      tick();
      reset = 1'b0;
      model_reset();
      check("mid_rst_gnt", 17'(gnt), 17'h0);
      check("mid_rst_done", 17'(done), 17'h0);
      check("mid_rst_busy", 17'(busy), 17'h0);
      check("mid_rst_r0", result0, 17'h0);
      tick();
      check("mid_rst_nodone", 17'(done), 17'h0);
      check("mid_rst_r0b", result0, 17'h0);

      // Port 1 raises req while port 0 is executing; it must be served afterwards.
      req      = 2'b01;
      op[0]    = OP_LOAD;
      operand0 = 16'h0F0F;
      tick();
      check("late_exec0", 17'(gnt), 17'h1);
      req      = 2'b10;
      op[1]    = OP_ACCUM;
      operand1 = 16'h0003;
      model_apply(0, OP_LOAD, 16'h0F0F);
      tick();
      check("late_done0", 17'(done), 17'h1);
      check_results("late0");
      tick();
      check("late_idle_gnt", 17'(gnt), 17'h0);
      check("late_idle_busy", 17'(busy), 17'h0);
      tick();
      check("late_exec1", 17'(gnt), 17'h2);
      req = 2'b00;
      model_apply(1, OP_ACCUM, 16'h0003);
      tick();
      check("late_done1", 17'(done), 17'h2);
      check_results("late1");
      tick();
      check("late_final_busy", 17'(busy), 17'h0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
         end else begin
            contend(int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
